// File: rtl/water_tank_sensor_model.sv
// Water-tank model: integrates valve commands into a saturating level and
// drives thermometer-coded low/mid/high sensor lines with stuck-at overrides.
module water_tank_sensor_model #(
  parameter int LEVEL_W  = 8,
  parameter int LOW_TH   = 10,
  parameter int MID_TH   = 100,
  parameter int HIGH_TH  = 200,
  parameter int STEP_DIV = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               fill,
  input  logic               drain,
  input  logic [2:0]         fault_en,
  input  logic [2:0]         fault_val,
  output logic               low,
  output logic               mid,
  output logic               high,
  output logic [LEVEL_W-1:0] level,
  output logic               empty,
  output logic               full,
  output logic               overflow,
  output logic               underflow,
  output logic [1:0]         phase
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(STEP_DIV - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;
  localparam logic [LEVEL_W-1:0] LOW_L     = LEVEL_W'(LOW_TH);
  localparam logic [LEVEL_W-1:0] MID_L     = LEVEL_W'(MID_TH);
  localparam logic [LEVEL_W-1:0] HIGH_L    = LEVEL_W'(HIGH_TH);

  if (!(LOW_TH > 0 && LOW_TH < MID_TH && MID_TH < HIGH_TH &&
        HIGH_TH <= (2 ** LEVEL_W) - 1 && STEP_DIV >= 1)) begin : g_bad_cfg
    $error("water_tank_sensor_model: illegal threshold/divider configuration");
  end

  // phase_q is the observable FSM state; it is exported directly on phase.
  typedef enum logic [1:0] {
    PH_IDLE      = 2'b00,
    PH_FILLING   = 2'b01,
    PH_DRAINING  = 2'b10,
    PH_SATURATED = 2'b11
  } phase_e;

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [2:0]         sens_q, sens_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  phase_e             phase_q, phase_d;

  logic step;
  logic do_fill;
  logic do_drain;
  logic at_max;
  logic at_zero;
  logic [2:0] raw_sens;

  assign step     = (div_cnt_q == DIV_LAST);
  assign do_fill  = fill & ~drain;
  assign do_drain = drain & ~fill;
  assign at_max   = (level_q == LEVEL_MAX);
  assign at_zero  = (level_q == '0);
  assign raw_sens = {level_q >= HIGH_L, level_q >= MID_L, level_q >= LOW_L};

  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    level_d   = level_q;
    ovf_d     = 1'b0;
    udf_d     = 1'b0;
    // Valves only matter in the step cycle; saturation loses the step instead of wrapping.
    if (step) begin
      if (do_fill) begin
        if (at_max) ovf_d   = 1'b1;
        else        level_d = level_q + 1'b1;
      end else if (do_drain) begin
        if (at_zero) udf_d   = 1'b1;
        else         level_d = level_q - 1'b1;
      end
    end
    sens_d = (fault_en & fault_val) | (~fault_en & raw_sens);
  end

  always_comb begin
    phase_d = PH_IDLE;
    if ((do_fill && at_max) || (do_drain && at_zero)) phase_d = PH_SATURATED;
    else if (do_fill)                                  phase_d = PH_FILLING;
    else if (do_drain)                                 phase_d = PH_DRAINING;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      level_q   <= '0;
      sens_q    <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      phase_q   <= PH_IDLE;
    end else begin
      div_cnt_q <= div_cnt_d;
      level_q   <= level_d;
      sens_q    <= sens_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      phase_q   <= phase_d;
    end
  end

  assign low       = sens_q[0];
  assign mid       = sens_q[1];
  assign high      = sens_q[2];
  assign level     = level_q;
  assign empty     = at_zero;
  assign full      = at_max;
  assign overflow  = ovf_q;
  assign underflow = udf_q;
  assign phase     = phase_q;

endmodule
